// File: rtl/lsu_wbu.sv
// Load/store unit merged with write-back: accepts one execute result at a time,
// performs an optional single-beat memory access, then retires it with a
// one-cycle register-file / CSR write and a retire pulse.
module lsu_wbu (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_men,
    input  logic        in_write,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [1:0]  in_mask,
    input  logic        in_rsign,
    input  logic [4:0]  in_ard,
    input  logic [31:0] in_rd,
    input  logic        in_gen,
    input  logic [11:0] in_acsr,
    input  logic [31:0] in_csr,
    input  logic        in_sen,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    input  logic        mem_resp_err,
    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        csr_wen,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        wb_done,
    output logic        lsu_fault
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;

    state_t      state;

    logic        r_men;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_mask;
    logic        r_rsign;
    logic [4:0]  r_ard;
    logic [31:0] r_rd;
    logic        r_gen;
    logic [11:0] r_acsr;
    logic [31:0] r_csr;
    logic        r_sen;
    logic [31:0] r_rdata;

    logic        misaligned;
    logic [31:0] shifted_rdata;
    logic [31:0] load_data;

    // Alignment check on the incoming request; only memory accesses can fault this way
    always_comb begin
        misaligned = 1'b0;
        if (in_men) begin
            if (in_mask == 2'b10 && in_addr[0])
                misaligned = 1'b1;
            else if (in_mask == 2'b11 && in_addr[1:0] != 2'b00)
                misaligned = 1'b1;
        end
    end

    // Transaction FSM: captures the instruction, runs the bus handshake and pulses retire outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            gpr_wen       <= 1'b0;
            csr_wen       <= 1'b0;
            wb_done       <= 1'b0;
            lsu_fault     <= 1'b0;
            r_men         <= 1'b0;
            r_write       <= 1'b0;
            r_addr        <= 32'h0;
            r_wdata       <= 32'h0;
            r_mask        <= 2'b00;
            r_rsign       <= 1'b0;
            r_ard         <= 5'h0;
            r_rd          <= 32'h0;
            r_gen         <= 1'b0;
            r_acsr        <= 12'h0;
            r_csr         <= 32'h0;
            r_sen         <= 1'b0;
            r_rdata       <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_men    <= in_men;
                        r_write  <= in_write;
                        r_addr   <= in_addr;
                        r_wdata  <= in_wdata;
                        r_mask   <= in_mask;
                        r_rsign  <= in_rsign;
                        r_ard    <= in_ard;
                        r_rd     <= in_rd;
                        r_gen    <= in_gen;
                        r_acsr   <= in_acsr;
                        r_csr    <= in_csr;
                        r_sen    <= in_sen;
                        r_rdata  <= 32'h0;
                        in_ready <= 1'b0;
                        if (!in_men || misaligned) begin
                            state     <= WB;
                            wb_done   <= 1'b1;
                            lsu_fault <= misaligned;
                            gpr_wen   <= in_gen && (in_ard != 5'd0) && !misaligned;
                            csr_wen   <= in_sen && !misaligned;
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (mem_resp_valid) begin
                        r_rdata   <= mem_resp_rdata;
                        state     <= WB;
                        wb_done   <= 1'b1;
                        lsu_fault <= mem_resp_err;
                        gpr_wen   <= r_gen && (r_ard != 5'd0) && !mem_resp_err && !r_write;
                        csr_wen   <= r_sen && !mem_resp_err;
                    end
                end
                WB: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    wb_done   <= 1'b0;
                    lsu_fault <= 1'b0;
                    gpr_wen   <= 1'b0;
                    csr_wen   <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Request fields come straight from captured state, so they hold steady while stalled
    always_comb begin
        mem_req_write = r_write;
        mem_req_addr  = {r_addr[31:2], 2'b00};
        mem_req_wdata = r_wdata << {r_addr[1:0], 3'b000};
        mem_req_wstrb = 4'b0000;
        if (r_write) begin
            case (r_mask)
                2'b01:   mem_req_wstrb = 4'b0001 << r_addr[1:0];
                2'b10:   mem_req_wstrb = 4'b0011 << {r_addr[1], 1'b0};
                2'b11:   mem_req_wstrb = 4'b1111;
                default: mem_req_wstrb = 4'b0000;
            endcase
        end
    end

    // Align the returned word to the accessed byte lane and extend to 32 bits
    always_comb begin
        shifted_rdata = r_rdata >> {r_addr[1:0], 3'b000};
        case (r_mask)
            2'b01:   load_data = {{24{r_rsign & shifted_rdata[7]}}, shifted_rdata[7:0]};
            2'b10:   load_data = {{16{r_rsign & shifted_rdata[15]}}, shifted_rdata[15:0]};
            default: load_data = shifted_rdata;
        endcase
    end

    // Write-back data paths; enables are the registered pulses from the FSM
    always_comb begin
        gpr_waddr = r_ard;
        gpr_wdata = (r_men && !r_write) ? load_data : r_rd;
        csr_waddr = r_acsr;
        csr_wdata = r_csr;
    end

endmodule

// File: tb/tb_lsu_wbu.sv
// Self-checking bench for lsu_wbu: table of instruction vectors with a bus
// responder and a scoreboard of expected retire results, plus reset sequences.
module tb_lsu_wbu;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_men;
    logic        in_write;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [1:0]  in_mask;
    logic        in_rsign;
    logic [4:0]  in_ard;
    logic [31:0] in_rd;
    logic        in_gen;
    logic [11:0] in_acsr;
    logic [31:0] in_csr;
    logic        in_sen;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        wb_done;
    logic        lsu_fault;

    lsu_wbu dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_men         (in_men),
        .in_write       (in_write),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_mask        (in_mask),
        .in_rsign       (in_rsign),
        .in_ard         (in_ard),
        .in_rd          (in_rd),
        .in_gen         (in_gen),
        .in_acsr        (in_acsr),
        .in_csr         (in_csr),
        .in_sen         (in_sen),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err),
        .gpr_wen        (gpr_wen),
        .gpr_waddr      (gpr_waddr),
        .gpr_wdata      (gpr_wdata),
        .csr_wen        (csr_wen),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .wb_done        (wb_done),
        .lsu_fault      (lsu_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        men;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mask;
        logic        rsign;
        logic [4:0]  ard;
        logic [31:0] rd;
        logic        gen;
        logic [11:0] acsr;
        logic [31:0] csr;
        logic        sen;
        logic [31:0] rdata;
        logic        err;
        int          delay;
        logic        exp_req;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_req_addr;
        logic [31:0] exp_req_wdata;
        logic        exp_gpr_wen;
        logic [31:0] exp_gpr_wdata;
        logic        exp_csr_wen;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic        gpr_wen;
        logic [4:0]  gpr_waddr;
        logic [31:0] gpr_wdata;
        logic        csr_wen;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
        logic        fault;
        int          latency;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   checks = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        in_valid = 1'b0; in_men = 1'b0; in_write = 1'b0; in_addr = 32'h0; in_wdata = 32'h0;
        in_mask = 2'b00; in_rsign = 1'b0; in_ard = 5'h0; in_rd = 32'h0; in_gen = 1'b0;
        in_acsr = 12'h0; in_csr = 32'h0; in_sen = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0; mem_resp_err = 1'b0;
    endtask

    // Drives one instruction from the IDLE negedge, acts as the bus, and scores the retire
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        exp_t got;
        int   stall = 0;
        bit   req_seen = 0;
        bit   resp_sent = 0;
        bit   done = 0;
        checkOutput({"in_ready_idle_", v.name}, {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1; in_men = v.men; in_write = v.write; in_addr = v.addr; in_wdata = v.wdata;
        in_mask = v.mask; in_rsign = v.rsign; in_ard = v.ard; in_rd = v.rd; in_gen = v.gen;
        in_acsr = v.acsr; in_csr = v.csr; in_sen = v.sen;
        e.gpr_wen = v.exp_gpr_wen; e.gpr_waddr = v.ard; e.gpr_wdata = v.exp_gpr_wdata;
        e.csr_wen = v.exp_csr_wen; e.csr_waddr = v.acsr; e.csr_wdata = v.csr;
        e.fault = v.exp_fault; e.latency = v.exp_req ? 3 + v.delay : 1;
        sb.push_back(e);
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clock);
            in_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
            mem_resp_rdata = 32'h0; mem_resp_err = 1'b0;
            if (wb_done) begin
                got = sb.pop_front();
                done = 1;
                checkOutput({"latency_", v.name}, k, got.latency);
                checkOutput({"fault_", v.name}, {31'h0, lsu_fault}, {31'h0, got.fault});
                checkOutput({"gpr_wen_", v.name}, {31'h0, gpr_wen}, {31'h0, got.gpr_wen});
                checkOutput({"csr_wen_", v.name}, {31'h0, csr_wen}, {31'h0, got.csr_wen});
                checkOutput({"req_low_at_wb_", v.name}, {31'h0, mem_req_valid}, 32'h0);
                if (got.gpr_wen) begin
                    checkOutput({"gpr_waddr_", v.name}, {27'h0, gpr_waddr}, {27'h0, got.gpr_waddr});
                    checkOutput({"gpr_wdata_", v.name}, gpr_wdata, got.gpr_wdata);
                end
                if (got.csr_wen) begin
                    checkOutput({"csr_waddr_", v.name}, {20'h0, csr_waddr}, {20'h0, got.csr_waddr});
                    checkOutput({"csr_wdata_", v.name}, csr_wdata, got.csr_wdata);
                end
            end else if (mem_req_valid) begin
                if (!v.exp_req) begin
                    checkOutput({"unexpected_req_", v.name}, 32'h1, 32'h0);
                end else begin
                    checkOutput({"req_write_", v.name}, {31'h0, mem_req_write}, {31'h0, v.write});
                    checkOutput({"req_addr_", v.name}, mem_req_addr, v.exp_req_addr);
                    checkOutput({"req_wstrb_", v.name}, {28'h0, mem_req_wstrb}, {28'h0, v.exp_wstrb});
                    checkOutput({"req_wdata_", v.name}, mem_req_wdata, v.exp_req_wdata);
                    checkOutput({"in_ready_busy_", v.name}, {31'h0, in_ready}, 32'h0);
                end
                if (stall >= v.delay) mem_req_ready = 1'b1;
                else stall++;
                req_seen = 1;
            end else if (req_seen && !resp_sent) begin
                mem_resp_valid = 1'b1; mem_resp_rdata = v.rdata; mem_resp_err = v.err;
                resp_sent = 1;
            end
        end
        if (!done) begin
            checkOutput({"timeout_", v.name}, 32'h0, 32'h1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(negedge clock);
        checkOutput({"wb_pulse_end_", v.name}, {31'h0, wb_done}, 32'h0);
        checkOutput({"back_to_idle_", v.name}, {31'h0, in_ready}, 32'h1);
    endtask

    task automatic checkQuiet(input string name);
        checkOutput({name, "_wb_done"}, {31'h0, wb_done}, 32'h0);
        checkOutput({name, "_gpr_wen"}, {31'h0, gpr_wen}, 32'h0);
        checkOutput({name, "_csr_wen"}, {31'h0, csr_wen}, 32'h0);
        checkOutput({name, "_fault"}, {31'h0, lsu_fault}, 32'h0);
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        vecs[0]  = '{"alu_rd5",     1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 5'd5,  32'h1234, 1'b1, 12'h0,   32'h0,        1'b0, 32'h0,        1'b0, 0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h1234,     1'b0, 1'b0};
        vecs[1]  = '{"alu_x0_csr",  1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b0, 5'd0,  32'h5555, 1'b1, 12'h305, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
        vecs[2]  = '{"lb_signed",   1'b1, 1'b0, 32'h80000003, 32'h0,        2'b01, 1'b1, 5'd10, 32'h999,  1'b1, 12'h0,   32'h0,        1'b0, 32'h80FF0000, 1'b0, 0, 1'b1, 4'b0000, 32'h80000000, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 1'b0};
        vecs[3]  = '{"lbu",         1'b1, 1'b0, 32'h80000003, 32'h0,        2'b01, 1'b0, 5'd10, 32'h999,  1'b1, 12'h0,   32'h0,        1'b0, 32'h80FF0000, 1'b0, 0, 1'b1, 4'b0000, 32'h80000000, 32'h0,        1'b1, 32'h00000080, 1'b0, 1'b0};
        vecs[4]  = '{"sh",          1'b1, 1'b1, 32'h80000002, 32'h0000ABCD, 2'b10, 1'b0, 5'd7,  32'h77,   1'b1, 12'h0,   32'h0,        1'b0, 32'h0,        1'b0, 0, 1'b1, 4'b1100, 32'h80000000, 32'hABCD0000, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[5]  = '{"lw_misalign", 1'b1, 1'b0, 32'h80000001, 32'h0,        2'b11, 1'b0, 5'd3,  32'h33,   1'b1, 12'h300, 32'h5,        1'b1, 32'h0,        1'b0, 0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
        vecs[6]  = '{"lw_err_stall",1'b1, 1'b0, 32'h80000010, 32'h11223344, 2'b11, 1'b0, 5'd9,  32'h99,   1'b1, 12'h341, 32'h1,        1'b1, 32'h55,       1'b1, 3, 1'b1, 4'b0000, 32'h80000010, 32'h11223344, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[7]  = '{"lh_signed",   1'b1, 1'b0, 32'h80000002, 32'h0,        2'b10, 1'b1, 5'd4,  32'h0,    1'b1, 12'h0,   32'h0,        1'b0, 32'h80011234, 1'b0, 0, 1'b1, 4'b0000, 32'h80000000, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 1'b0};
        vecs[8]  = '{"lhu_stall1",  1'b1, 1'b0, 32'h80000000, 32'h0,        2'b10, 1'b0, 5'd4,  32'h0,    1'b1, 12'h0,   32'h0,        1'b0, 32'hFFFF8765, 1'b0, 1, 1'b1, 4'b0000, 32'h80000000, 32'h0,        1'b1, 32'h00008765, 1'b0, 1'b0};
        vecs[9]  = '{"sb",          1'b1, 1'b1, 32'h80000001, 32'h000000A5, 2'b01, 1'b0, 5'd6,  32'h66,   1'b1, 12'h0,   32'h0,        1'b0, 32'h0,        1'b0, 0, 1'b1, 4'b0010, 32'h80000000, 32'h0000A500, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{"lw_csr",      1'b1, 1'b0, 32'h80000008, 32'h0,        2'b11, 1'b0, 5'd12, 32'h0,    1'b1, 12'h300, 32'h1800,     1'b1, 32'hCAFEBABE, 1'b0, 0, 1'b1, 4'b0000, 32'h80000008, 32'h0,        1'b1, 32'hCAFEBABE, 1'b1, 1'b0};
        vecs[11] = '{"sh_misalign", 1'b1, 1'b1, 32'h80000003, 32'h1234,     2'b10, 1'b0, 5'd2,  32'h22,   1'b1, 12'h0,   32'h0,        1'b0, 32'h0,        1'b0, 0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
        vecs[12] = '{"lb_pos",      1'b1, 1'b0, 32'h80000001, 32'h0,        2'b01, 1'b1, 5'd13, 32'h0,    1'b1, 12'h0,   32'h0,        1'b0, 32'h00007F00, 1'b0, 0, 1'b1, 4'b0000, 32'h80000000, 32'h0,        1'b1, 32'h0000007F, 1'b0, 1'b0};
        vecs[13] = '{"sw",          1'b1, 1'b1, 32'h80000004, 32'hCAFEF00D, 2'b11, 1'b0, 5'd1,  32'h11,   1'b0, 12'h0,   32'h0,        1'b0, 32'h0,        1'b0, 2, 1'b1, 4'b1111, 32'h80000004, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clock);
        checkOutput("reset_in_ready", {31'h0, in_ready}, 32'h1);
        checkOutput("reset_req_valid", {31'h0, mem_req_valid}, 32'h0);
        checkOutput("reset_gpr_wdata", gpr_wdata, 32'h0);
        checkOutput("reset_req_addr", mem_req_addr, 32'h0);
        checkQuiet("reset");
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post_reset_in_ready", {31'h0, in_ready}, 32'h1);

        // Stray response while idle must be ignored
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h12345678;
        repeat (2) begin
            @(negedge clock);
            checkQuiet("stray_idle");
            checkOutput("stray_idle_in_ready", {31'h0, in_ready}, 32'h1);
        end
        mem_resp_valid = 1'b0;

        for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

        // Reset while waiting for the response abandons the load
        in_valid = 1'b1; in_men = 1'b1; in_addr = 32'h80000020; in_mask = 2'b11; in_ard = 5'd8; in_gen = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        checkOutput("rst_resp_req_valid", {31'h0, mem_req_valid}, 32'h1);
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        checkOutput("rst_resp_in_resp", {31'h0, mem_req_valid | in_ready}, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rst_resp_in_ready", {31'h0, in_ready}, 32'h1);
        checkQuiet("rst_resp_after");
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hA5A5A5A5;
        repeat (2) begin
            @(negedge clock);
            checkQuiet("rst_resp_stray");
            checkOutput("rst_resp_stray_in_ready", {31'h0, in_ready}, 32'h1);
        end
        mem_resp_valid = 1'b0;

        // Reset while the request is stalled drops the request
        in_valid = 1'b1; in_write = 1'b1; in_addr = 32'h80000040; in_wdata = 32'h77; in_mask = 2'b01;
        @(negedge clock);
        clearInputs();
        checkOutput("rst_req_valid", {31'h0, mem_req_valid}, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rst_req_dropped", {31'h0, mem_req_valid}, 32'h0);
        checkOutput("rst_req_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clock);
        checkQuiet("rst_req_after");
        checkOutput("rst_req_still_low", {31'h0, mem_req_valid}, 32'h0);

        // Normal operation resumes after the abandoned transactions
        applyStimulus(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_wbu.md
LSU_WBU -- requirements
Module: ysyx_25040111_lsu

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed.
REQ-002 clock  in  1  system clock, all state on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 in_valid/in_ready  in/out  1/1  upstream execute-result handshake; transfer when both high.
REQ-005 in_men  in  1  memory access required.
REQ-006 in_write  in  1  store when high, load when low; meaningful only with in_men.
REQ-007 in_addr/in_wdata  in  32/32  byte address and store data.
REQ-008 in_mask  in  2  size: 01 byte, 10 half, 11 word, 00 none.
REQ-009 in_rsign  in  1  sign-extend load result.
REQ-010 in_ard/in_rd/in_gen  in  5/32/1  GPR destination, ALU result, GPR write enable.
REQ-011 in_acsr/in_csr/in_sen  in  12/32/1  CSR address, CSR data, CSR write enable.
REQ-012 mem_req_valid/mem_req_ready  out/in  1/1  memory request handshake.
REQ-013 mem_req_write/mem_req_addr/mem_req_wdata/mem_req_wstrb  out  1/32/32/4  request fields.
REQ-014 mem_resp_valid/mem_resp_rdata/mem_resp_err  in  1/32/1  response; consumed in the cycle it is valid.
REQ-015 gpr_wen/gpr_waddr/gpr_wdata  out  1/5/32  register-file write port.
REQ-016 csr_wen/csr_waddr/csr_wdata  out  1/12/32  CSR write port.
REQ-017 wb_done  out  1  one-cycle pulse, instruction retired.
REQ-018 lsu_fault  out  1  one-cycle pulse, misaligned or bus error; coincides with wb_done.

Function
REQ-019 SHALL implement states IDLE, REQ, RESP, WB; in_ready high only in IDLE.
REQ-020 On in_valid&in_ready, SHALL register all in_* fields; IDLE->WB if in_men=0 or misaligned, else IDLE->REQ.
REQ-021 Misaligned: half with addr[0]=1, word with addr[1:0]!=0; no bus request issued.
REQ-022 REQ: mem_req_valid=1 with fields stable until mem_req_ready; on handshake ->RESP.
REQ-023 RESP: on mem_resp_valid capture rdata/err, ->WB; wait indefinitely otherwise.
REQ-024 WB: wb_done, gpr_wen, csr_wen asserted for exactly one cycle; ->IDLE next cycle.
REQ-025 mem_req_addr SHALL be in_addr with bits [1:0] forced to 0.
REQ-026 wstrb: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111; loads 0000.
REQ-027 mem_req_wdata SHALL be in_wdata shifted left by 8*addr[1:0].
REQ-028 Load data SHALL be rdata shifted right by 8*addr[1:0], truncated to size, sign- or zero-extended per in_rsign.
REQ-029 gpr_wdata SHALL be load data for loads, else in_rd; gpr_waddr=in_ard.
REQ-030 gpr_wen=in_gen & (in_ard!=0) & ~fault; stores SHALL never write GPR.
REQ-031 csr_wen=in_sen & ~fault; csr_waddr=in_acsr; csr_wdata=in_csr.
REQ-032 Fault (misaligned or mem_resp_err) SHALL pulse lsu_fault with wb_done; no GPR/CSR write.
REQ-033 Latency: non-memory accept cycle N -> wb_done N+1; memory with zero-wait bus: req N+1, resp N+2, wb_done N+3.
REQ-034 mem_resp_valid outside RESP SHALL be ignored.

Reset
REQ-035 Reset SHALL force IDLE; all outputs 0 except in_ready=1; captured fields cleared to 0.
REQ-036 Reset mid-REQ/RESP SHALL abandon the transaction; no write or wb_done issued; later stray responses ignored.

Verification
REQ-037 ALU op ard=5 rd=0x1234 gen=1 -> cycle N+1 gpr_wen=1, waddr=5, wdata=0x1234, wb_done=1.
REQ-038 Signed byte load addr=0x8000_0003, rdata=0x80FF_0000 -> gpr_wdata=0xFFFF_FF80; rsign=0 -> 0x0000_0080.
REQ-039 Half store addr=0x8000_0002 wdata=0xABCD -> wstrb=1100, req wdata=0xABCD_0000, addr=0x8000_0000, gpr_wen=0.
REQ-040 Word load addr=0x8000_0001 -> no mem_req_valid, lsu_fault=1 and wb_done=1 at N+1, gpr_wen=0.
REQ-041 mem_req_ready held low 3 cycles then high -> request fields stable throughout; mem_resp_err=1 -> lsu_fault, no GPR write.
REQ-042 Reset asserted in RESP -> IDLE, in_ready=1; subsequent mem_resp_valid -> no gpr_wen, no wb_done.
